// File: rtl/key_debouncer_pkg.sv
// Board-level constants for DE1-SoC push-buttons and a small helper shared by the
// key debouncer and later KEY-driven labs.
package key_debouncer_pkg;

  localparam int   CLK_HZ                       = 50_000_000;
  localparam int   N_KEYS_DE1                   = 4;
  localparam logic KEY_ACTIVE                   = 1'b0;
  localparam int   DEFAULT_DEBOUNCE_CYCLES      = 500_000;
  localparam int   DEFAULT_REPEAT_DELAY_CYCLES  = 25_000_000;
  localparam int   DEFAULT_REPEAT_PERIOD_CYCLES = 5_000_000;

  function automatic logic is_pressed(input logic key_raw);
    return key_raw == KEY_ACTIVE;
  endfunction

endpackage

// File: rtl/key_debounce_cell.sv
// One-key debouncer: 2-flop synchronizer, stability counter, registered level and pulses.
// Auto-repeat of key_press while held is built only when KEY_AUTOREPEAT_EN is defined.
module key_debounce_cell
  import key_debouncer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES      = DEFAULT_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY_CYCLES  = DEFAULT_REPEAT_DELAY_CYCLES,
  parameter int REPEAT_PERIOD_CYCLES = DEFAULT_REPEAT_PERIOD_CYCLES
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic key_raw_i,
  output logic level_o,
  output logic press_o,
  output logic release_o
);

  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // The reload arithmetic of the repeat counter needs delay >= period >= 1.
  if (DEBOUNCE_CYCLES < 1 || REPEAT_PERIOD_CYCLES < 1 ||
      REPEAT_DELAY_CYCLES < REPEAT_PERIOD_CYCLES) begin : g_cfg_err
    $error("key_debounce_cell: invalid cycle parameters");
  end

  logic             sync1_q, sync2_q;
  logic             raw_pressed;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             repeat_hit;

  assign raw_pressed = is_pressed(sync2_q);

  always_comb begin
    cnt_d     = cnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    if (raw_pressed == level_q) begin
      cnt_d = '0;
    end else if (cnt_q >= CNT_LAST) begin
      level_d   = raw_pressed;
      cnt_d     = '0;
      press_d   = raw_pressed;
      release_d = ~raw_pressed;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

`ifdef KEY_AUTOREPEAT_EN
  localparam int               HOLD_W      = $clog2(REPEAT_DELAY_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_W'(REPEAT_DELAY_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(REPEAT_DELAY_CYCLES - REPEAT_PERIOD_CYCLES);

  logic [HOLD_W-1:0] hold_q, hold_d;

  // Reloading to DELAY-PERIOD makes every later repeat land PERIOD cycles apart.
  always_comb begin
    hold_d     = hold_q;
    repeat_hit = 1'b0;
    if (!level_q || (level_d != level_q)) begin
      hold_d = '0;
    end else if (hold_q >= HOLD_LAST) begin
      hold_d     = HOLD_RELOAD;
      repeat_hit = 1'b1;
    end else begin
      hold_d = hold_q + HOLD_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) hold_q <= '0;
    else         hold_q <= hold_d;
  end
`else
  assign repeat_hit = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q   <= ~KEY_ACTIVE;
      sync2_q   <= ~KEY_ACTIVE;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync1_q   <= key_raw_i;
      sync2_q   <= sync1_q;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d | repeat_hit;
      release_q <= release_d;
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;

endmodule

// File: rtl/key_debouncer.sv
// Debounces N_KEYS raw active-low DE1-SoC buttons into clean levels and press/release pulses.
// Optional auto-repeat of key_press is enabled by defining KEY_AUTOREPEAT_EN.
module key_debouncer
  import key_debouncer_pkg::*;
#(
  parameter int N_KEYS               = N_KEYS_DE1,
  parameter int DEBOUNCE_CYCLES      = DEFAULT_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY_CYCLES  = DEFAULT_REPEAT_DELAY_CYCLES,
  parameter int REPEAT_PERIOD_CYCLES = DEFAULT_REPEAT_PERIOD_CYCLES
) (
  input  logic              CLOCK_50,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] KEY,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release
);

  for (genvar i = 0; i < N_KEYS; i++) begin : g_key
    key_debounce_cell #(
      .DEBOUNCE_CYCLES     (DEBOUNCE_CYCLES),
      .REPEAT_DELAY_CYCLES (REPEAT_DELAY_CYCLES),
      .REPEAT_PERIOD_CYCLES(REPEAT_PERIOD_CYCLES)
    ) u_cell (
      .clk_i    (CLOCK_50),
      .rst_ni   (rst_n),
      .key_raw_i(KEY[i]),
      .level_o  (key_level[i]),
      .press_o  (key_press[i]),
      .release_o(key_release[i])
    );
  end

endmodule

// File: tb/tb_key_debouncer.sv
// Directed bench for key_debouncer with DEBOUNCE=8, REPEAT_DELAY=20, REPEAT_PERIOD=6.
// Expected repeat timing follows KEY_AUTOREPEAT_EN when the macro is defined.
module tb_key_debouncer;

  logic       CLOCK_50 = 1'b0;
  logic       rst_n    = 1'b1;
  logic [3:0] KEY      = 4'b1111;
  logic [3:0] key_level, key_press, key_release;

  int n_pass  = 0;
  int n_total = 0;

  logic [3:0] lvl_h[0:127];
  logic [3:0] prs_h[0:127];
  logic [3:0] rel_h[0:127];

  key_debouncer #(
    .N_KEYS              (4),
    .DEBOUNCE_CYCLES     (8),
    .REPEAT_DELAY_CYCLES (20),
    .REPEAT_PERIOD_CYCLES(6)
  ) dut (
    .CLOCK_50   (CLOCK_50),
    .rst_n      (rst_n),
    .KEY        (KEY),
    .key_level  (key_level),
    .key_press  (key_press),
    .key_release(key_release)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  // Record outputs at negedges numbered lo..lo+n-1 (cycle 1 = first after stimulus change).
  task automatic observe(input int lo, input int n);
    for (int c = lo; c < lo + n; c++) begin
      @(negedge CLOCK_50);
      lvl_h[c] = key_level;
      prs_h[c] = key_press;
      rel_h[c] = key_release;
    end
  endtask

  function automatic int npress(input int k, input int lo, input int hi);
    int s;
    s = 0;
    for (int c = lo; c <= hi; c++) s += int'(prs_h[c][k]);
    return s;
  endfunction

  function automatic int nrel(input int k, input int lo, input int hi);
    int s;
    s = 0;
    for (int c = lo; c <= hi; c++) s += int'(rel_h[c][k]);
    return s;
  endfunction

  task automatic test_reset();
    #1 rst_n = 1'b0;
    KEY = 4'b1110;
    repeat (3) @(negedge CLOCK_50);
    n_total++; if (key_level !== 4'b0000) $display("FAIL rst_level got %b exp 0000", key_level); else n_pass++;
    n_total++; if (key_press !== 4'b0000) $display("FAIL rst_press got %b exp 0000", key_press); else n_pass++;
    n_total++; if (key_release !== 4'b0000) $display("FAIL rst_release got %b exp 0000", key_release); else n_pass++;
    rst_n = 1'b1;
    observe(1, 14);
    n_total++; if (lvl_h[9] !== 4'b0000) $display("FAIL rst_exit_lvl9 got %b exp 0000", lvl_h[9]); else n_pass++;
    n_total++; if (lvl_h[10] !== 4'b0001) $display("FAIL rst_exit_lvl10 got %b exp 0001", lvl_h[10]); else n_pass++;
    n_total++; if (prs_h[10] !== 4'b0001) $display("FAIL rst_exit_press10 got %b exp 0001", prs_h[10]); else n_pass++;
    n_total++; if (npress(0, 1, 14) !== 1) $display("FAIL rst_exit_npress got %0d exp 1", npress(0, 1, 14)); else n_pass++;
  endtask

  task automatic test_release();
    KEY = 4'b1111;
    observe(1, 14);
    n_total++; if (lvl_h[9] !== 4'b0001) $display("FAIL rel_lvl9 got %b exp 0001", lvl_h[9]); else n_pass++;
    n_total++; if (lvl_h[10] !== 4'b0000) $display("FAIL rel_lvl10 got %b exp 0000", lvl_h[10]); else n_pass++;
    n_total++; if (rel_h[10] !== 4'b0001) $display("FAIL rel_pulse10 got %b exp 0001", rel_h[10]); else n_pass++;
    n_total++; if (nrel(0, 1, 14) !== 1) $display("FAIL rel_count got %0d exp 1", nrel(0, 1, 14)); else n_pass++;
    n_total++; if (npress(0, 1, 14) !== 0) $display("FAIL rel_no_press got %0d exp 0", npress(0, 1, 14)); else n_pass++;
  endtask

  task automatic test_bounce();
    int changes;
    changes = 0;
    for (int seg = 0; seg < 10; seg++) begin
      KEY[0] = (seg % 2 == 0) ? 1'b0 : 1'b1;
      observe(1, 3);
      for (int c = 1; c <= 3; c++)
        if (lvl_h[c] !== 4'b0000 || prs_h[c] !== 4'b0000 || rel_h[c] !== 4'b0000) changes++;
    end
    n_total++; if (changes !== 0) $display("FAIL bounce_quiet got %0d exp 0", changes); else n_pass++;
    KEY[0] = 1'b0;
    observe(1, 14);
    n_total++; if (lvl_h[9] !== 4'b0000) $display("FAIL bounce_lvl9 got %b exp 0000", lvl_h[9]); else n_pass++;
    n_total++; if (lvl_h[10] !== 4'b0001) $display("FAIL bounce_lvl10 got %b exp 0001", lvl_h[10]); else n_pass++;
    n_total++; if (prs_h[10] !== 4'b0001) $display("FAIL bounce_press10 got %b exp 0001", prs_h[10]); else n_pass++;
    n_total++; if (npress(0, 1, 14) !== 1) $display("FAIL bounce_npress got %0d exp 1", npress(0, 1, 14)); else n_pass++;
    KEY = 4'b1111;
    observe(1, 14);
    n_total++; if (rel_h[10] !== 4'b0001) $display("FAIL bounce_release got %b exp 0001", rel_h[10]); else n_pass++;
  endtask

  task automatic test_simultaneous();
    int overlap;
    overlap = 0;
    KEY = 4'b0110;
    observe(1, 14);
    n_total++; if (prs_h[9] !== 4'b0000) $display("FAIL sim_press9 got %b exp 0000", prs_h[9]); else n_pass++;
    n_total++; if (prs_h[10] !== 4'b1001) $display("FAIL sim_press10 got %b exp 1001", prs_h[10]); else n_pass++;
    n_total++; if (prs_h[11] !== 4'b0000) $display("FAIL sim_press11 got %b exp 0000", prs_h[11]); else n_pass++;
    n_total++; if (lvl_h[10] !== 4'b1001) $display("FAIL sim_lvl10 got %b exp 1001", lvl_h[10]); else n_pass++;
    for (int c = 1; c <= 14; c++) if ((prs_h[c] & rel_h[c]) !== 4'b0000) overlap++;
    KEY = 4'b1111;
    observe(1, 14);
    for (int c = 1; c <= 14; c++) if ((prs_h[c] & rel_h[c]) !== 4'b0000) overlap++;
    n_total++; if (rel_h[10] !== 4'b1001) $display("FAIL sim_release10 got %b exp 1001", rel_h[10]); else n_pass++;
    n_total++; if (lvl_h[10] !== 4'b0000) $display("FAIL sim_rel_lvl10 got %b exp 0000", lvl_h[10]); else n_pass++;
    n_total++; if (overlap !== 0) $display("FAIL sim_exclusive got %0d exp 0", overlap); else n_pass++;
  endtask

  task automatic test_glitch();
    int seen;
    seen = 0;
    KEY = 4'b1011;
    observe(1, 7);
    KEY = 4'b1111;
    observe(8, 14);
    for (int c = 1; c <= 21; c++)
      if (lvl_h[c] !== 4'b0000 || prs_h[c] !== 4'b0000 || rel_h[c] !== 4'b0000) seen++;
    n_total++; if (seen !== 0) $display("FAIL glitch7_quiet got %0d exp 0", seen); else n_pass++;
    // One cycle longer than the glitch is just enough to be accepted.
    KEY = 4'b1011;
    observe(1, 8);
    KEY = 4'b1111;
    observe(9, 16);
    n_total++; if (prs_h[10] !== 4'b0100) $display("FAIL glitch8_press10 got %b exp 0100", prs_h[10]); else n_pass++;
    n_total++; if (lvl_h[17] !== 4'b0100) $display("FAIL glitch8_lvl17 got %b exp 0100", lvl_h[17]); else n_pass++;
    n_total++; if (rel_h[18] !== 4'b0100) $display("FAIL glitch8_rel18 got %b exp 0100", rel_h[18]); else n_pass++;
    n_total++; if (lvl_h[18] !== 4'b0000) $display("FAIL glitch8_lvl18 got %b exp 0000", lvl_h[18]); else n_pass++;
  endtask

  task automatic test_reset_mid();
    KEY = 4'b0111;
    observe(1, 12);
    n_total++; if (lvl_h[10] !== 4'b1000) $display("FAIL mid_lvl10 got %b exp 1000", lvl_h[10]); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_total++; if (key_level !== 4'b0000) $display("FAIL mid_async_clear got %b exp 0000", key_level); else n_pass++;
    @(negedge CLOCK_50);
    rst_n = 1'b1;
    observe(1, 12);
    n_total++; if (prs_h[1] !== 4'b0000) $display("FAIL mid_exit_nopulse got %b exp 0000", prs_h[1]); else n_pass++;
    n_total++; if (prs_h[10] !== 4'b1000) $display("FAIL mid_exit_press10 got %b exp 1000", prs_h[10]); else n_pass++;
    n_total++; if (npress(3, 1, 12) !== 1) $display("FAIL mid_exit_npress got %0d exp 1", npress(3, 1, 12)); else n_pass++;
    KEY = 4'b1111;
    observe(1, 14);
    n_total++; if (rel_h[10] !== 4'b1000) $display("FAIL mid_release got %b exp 1000", rel_h[10]); else n_pass++;
  endtask

  task automatic test_autorepeat();
    int exp_n;
    int exp_c[8];
`ifdef KEY_AUTOREPEAT_EN
    exp_n = 8;
    exp_c = '{10, 30, 36, 42, 48, 54, 60, 66};
`else
    exp_n = 1;
    exp_c = '{10, 0, 0, 0, 0, 0, 0, 0};
`endif
    KEY = 4'b1101;
    observe(1, 60);
    KEY = 4'b1111;
    observe(61, 20);
    n_total++; if (npress(1, 1, 80) !== exp_n) $display("FAIL rpt_count got %0d exp %0d", npress(1, 1, 80), exp_n); else n_pass++;
    for (int j = 0; j < exp_n; j++) begin
      n_total++;
      if (prs_h[exp_c[j]] !== 4'b0010) $display("FAIL rpt_pulse_c%0d got %b exp 0010", exp_c[j], prs_h[exp_c[j]]);
      else n_pass++;
    end
    n_total++; if (prs_h[29] !== 4'b0000) $display("FAIL rpt_early29 got %b exp 0000", prs_h[29]); else n_pass++;
    n_total++; if (rel_h[70] !== 4'b0010) $display("FAIL rpt_release70 got %b exp 0010", rel_h[70]); else n_pass++;
    n_total++; if (nrel(1, 1, 80) !== 1) $display("FAIL rpt_nrel got %0d exp 1", nrel(1, 1, 80)); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_release();
    test_bounce();
    test_simultaneous();
    test_glitch();
    test_reset_mid();
    test_autorepeat();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
